// File: rtl/ttl_bus_driver.sv
// rtl/ttl_bus_driver.sv - parametrised '244/'374/'373 bus driver with float value; optional open-bus decay under BUS_DECAY_EN
module ttl_bus_driver #(
    parameter int unsigned      WIDTH        = 4,
    parameter int unsigned      CHANNELS     = 2,
    parameter int unsigned      MODE         = 0,
    parameter logic [WIDTH-1:0] FLOAT_VALUE  = {WIDTH{1'b1}},
    parameter int unsigned      DECAY_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic [CHANNELS-1:0]       n_oe,
    input  logic                      ttl_clk,
    input  logic                      le,
    input  logic [CHANNELS*WIDTH-1:0] a,
    output logic [CHANNELS*WIDTH-1:0] y,
    output logic [CHANNELS-1:0]       y_drv
);

    logic                      r_ttl_clk_d;
    logic [CHANNELS*WIDTH-1:0] r_q;
    logic                      w_ttl_rise;
    logic [CHANNELS*WIDTH-1:0] w_d;
    logic [CHANNELS*WIDTH-1:0] w_float;

    assign w_ttl_rise = ttl_clk & ~r_ttl_clk_d;

    // Stored value: '374 captures on the emulated clock rising edge, '373 follows a while le is high
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_ttl_clk_d <= 1'b0;
            r_q         <= '0;
        end else begin
            r_ttl_clk_d <= ttl_clk;
            if ((MODE == 1 && w_ttl_rise) || (MODE == 2 && le)) begin
                r_q <= a;
            end
        end
    end

    // Driven value per emulated part; the latch is transparent while le is high
    always_comb begin
        case (MODE)
            1:       w_d = r_q;
            2:       w_d = le ? a : r_q;
            default: w_d = a;
        endcase
    end

`ifdef BUS_DECAY_EN
    localparam int unsigned      CNT_W    = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DECAY_CYCLES);

    logic [CHANNELS*WIDTH-1:0] r_hold;
    logic [CHANNELS*CNT_W-1:0] r_cnt;

    // Remember the last driven value and count down the open-bus hold time once disabled
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_hold <= '0;
            r_cnt  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!n_oe[c]) begin
                    r_hold[c*WIDTH +: WIDTH] <= w_d[c*WIDTH +: WIDTH];
                    r_cnt[c*CNT_W +: CNT_W]  <= CNT_LOAD;
                end else if (r_cnt[c*CNT_W +: CNT_W] != '0) begin
                    r_cnt[c*CNT_W +: CNT_W]  <= r_cnt[c*CNT_W +: CNT_W] - CNT_W'(1);
                end
            end
        end
    end

    // A disabled channel shows its held value until the counter expires, then floats
    always_comb begin
        w_float = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_float[c*WIDTH +: WIDTH] = (r_cnt[c*CNT_W +: CNT_W] != '0) ? r_hold[c*WIDTH +: WIDTH]
                                                                          : FLOAT_VALUE;
        end
    end
`else
    logic w_unused_decay;
    assign w_unused_decay = |DECAY_CYCLES;

    // Without decay a disabled channel floats immediately
    always_comb begin
        w_float = {CHANNELS{FLOAT_VALUE}};
    end
`endif

    // Per-channel output enable gating, combinational from n_oe
    always_comb begin
        y     = '0;
        y_drv = ~n_oe;
        for (int c = 0; c < CHANNELS; c++) begin
            y[c*WIDTH +: WIDTH] = n_oe[c] ? w_float[c*WIDTH +: WIDTH] : w_d[c*WIDTH +: WIDTH];
        end
    end

endmodule

// File: tb/tb_ttl_bus_driver.sv
// tb/tb_ttl_bus_driver.sv - scoreboard bench for ttl_bus_driver in all three modes, decay checked when BUS_DECAY_EN is set
module tb_ttl_bus_driver;

    localparam int          DC    = 16;
    localparam logic [3:0]  FLOAT = 4'hF;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [1:0] n_oe = 2'b11;
    logic       ttl_clk = 1'b0;
    logic       le = 1'b0;
    logic [7:0] a = 8'h00;

    logic [7:0] y0, y1, y2;
    logic [1:0] drv0, drv1, drv2;

    always #5 clk = ~clk;

    ttl_bus_driver #(.WIDTH(4), .CHANNELS(2), .MODE(0), .FLOAT_VALUE(4'hF), .DECAY_CYCLES(DC)) u0 (
        .clk(clk), .n_reset(n_reset), .n_oe(n_oe), .ttl_clk(ttl_clk), .le(le), .a(a), .y(y0), .y_drv(drv0));
    ttl_bus_driver #(.WIDTH(4), .CHANNELS(2), .MODE(1), .FLOAT_VALUE(4'hF), .DECAY_CYCLES(DC)) u1 (
        .clk(clk), .n_reset(n_reset), .n_oe(n_oe), .ttl_clk(ttl_clk), .le(le), .a(a), .y(y1), .y_drv(drv1));
    ttl_bus_driver #(.WIDTH(4), .CHANNELS(2), .MODE(2), .FLOAT_VALUE(4'hF), .DECAY_CYCLES(DC)) u2 (
        .clk(clk), .n_reset(n_reset), .n_oe(n_oe), .ttl_clk(ttl_clk), .le(le), .a(a), .y(y2), .y_drv(drv2));

    typedef struct packed {
        logic [7:0] y0, y1, y2;
        logic [1:0] drv;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the stored byte of the register and latch parts, the previous
    // emulated clock level, and per instance/channel last driven nibble plus remaining hold time.
    logic [7:0] m_q1 = 8'h00;
    logic [7:0] m_q2 = 8'h00;
    logic       m_tprev = 1'b0;
    logic [3:0] m_hold [3][2];
    int         m_left [3][2];

    function automatic logic [7:0] drive_val(int m, logic [7:0] av, logic lev);
        if (m == 0) return av;
        if (m == 1) return m_q1;
        return lev ? av : m_q2;
    endfunction

    task automatic model_edge();
        logic [7:0] d [3];
        for (int m = 0; m < 3; m++) d[m] = drive_val(m, a, le);
        if (!n_reset) begin
            m_q1 = 8'h00;
            m_q2 = 8'h00;
            m_tprev = 1'b0;
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < 2; c++) begin
                    m_hold[m][c] = 4'h0;
                    m_left[m][c] = 0;
                end
        end else begin
            if (ttl_clk && !m_tprev) m_q1 = a;
            m_tprev = ttl_clk;
            if (le) m_q2 = a;
`ifdef BUS_DECAY_EN
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < 2; c++) begin
                    if (!n_oe[c]) begin
                        m_hold[m][c] = d[m][c*4 +: 4];
                        m_left[m][c] = DC;
                    end else if (m_left[m][c] > 0) begin
                        m_left[m][c] = m_left[m][c] - 1;
                    end
                end
`endif
        end
    endtask

    function automatic exp_t expect_now();
        exp_t       e;
        logic [7:0] yv [3];
        for (int m = 0; m < 3; m++) begin
            logic [7:0] d;
            d = drive_val(m, a, le);
            for (int c = 0; c < 2; c++) begin
                if (!n_oe[c])
                    yv[m][c*4 +: 4] = d[c*4 +: 4];
                else if (m_left[m][c] > 0)
                    yv[m][c*4 +: 4] = m_hold[m][c];
                else
                    yv[m][c*4 +: 4] = FLOAT;
            end
        end
        e.y0  = yv[0];
        e.y1  = yv[1];
        e.y2  = yv[2];
        e.drv = ~n_oe;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus right after the edge and queue the expected response
    task automatic step(input logic rst, input logic [1:0] noe, input logic tc, input logic l, input logic [7:0] av);
        @(posedge clk);
        #1;
        model_edge();
        n_reset = rst;
        n_oe    = noe;
        ttl_clk = tc;
        le      = l;
        a       = av;
        sb.push_back(expect_now());
    endtask

    // Monitor: compare every queued expectation at mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mode0_y", int'(y0), int'(e.y0));
                check("mode1_y", int'(y1), int'(e.y1));
                check("mode2_y", int'(y2), int'(e.y2));
                check("mode0_y_drv", int'(drv0), int'(e.drv));
                check("mode1_y_drv", int'(drv1), int'(e.drv));
                check("mode2_y_drv", int'(drv2), int'(e.drv));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] noe_r;
        logic       tc_r, le_r, rst_r;
        for (int m = 0; m < 3; m++)
            for (int c = 0; c < 2; c++) begin
                m_hold[m][c] = 4'h0;
                m_left[m][c] = 0;
            end

        // Reset with mixed enables
        step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);

        // Buffer style enable gating
        step(1'b1, 2'b10, 1'b0, 1'b0, 8'h5A);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h5A);

        // Register capture: held-high clock captures once, later data ignored
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h3C);
        step(1'b1, 2'b00, 1'b1, 1'b0, 8'h3C);
        step(1'b1, 2'b00, 1'b1, 1'b0, 8'h3C);
        step(1'b1, 2'b00, 1'b1, 1'b0, 8'hFF);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'hFF);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'hFF);

        // Transparent latch then hold
        step(1'b1, 2'b00, 1'b0, 1'b1, 8'h12);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h12);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h34);

        // Drive A5 everywhere, then disable long enough to see the full decay
        step(1'b1, 2'b00, 1'b0, 1'b1, 8'hA5);
        step(1'b1, 2'b00, 1'b1, 1'b1, 8'hA5);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < DC + 4; i++) step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < DC + 4; i++) step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);

        // Reset mid-operation with stored 77 and decay in progress on channel 0
        step(1'b1, 2'b00, 1'b1, 1'b1, 8'h77);
        step(1'b1, 2'b00, 1'b0, 1'b0, 8'h77);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h77);
        step(1'b0, 2'b01, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 1'b0, 1'b0, 8'h77);

        // Randomised traffic with sticky enables so decay windows occur
        noe_r = 2'b00;
        tc_r  = 1'b0;
        le_r  = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 9) == 0) noe_r[c] = ~noe_r[c];
            if ($urandom_range(0, 2) == 0) tc_r = ~tc_r;
            if ($urandom_range(0, 3) == 0) le_r = ~le_r;
            rst_r = ($urandom_range(0, 79) != 0);
            step(rst_r, noe_r, tc_r, le_r, 8'($urandom_range(0, 255)));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
